// File: rtl/fetch_decode.sv
`default_nettype none
// ============================================================================
// Module   : fetch_decode
// Purpose  : Sequential Y86-64 fetch and decode. On an accepted start the
//            block reads one instruction byte by byte from a byte-wide
//            instruction memory. It then presents the instruction fields,
//            valC, valP, the status code, and the register-file read/write
//            IDs (4'hF = none).
// Ports    : clock, reset          - clock, synchronous active-high reset
//            start_i, pc_i         - fetch request and instruction address
//            imem_req_o/addr_o     - byte read request and address
//            imem_valid_i/rdata_i/error_i - memory response
//            busy_o, done_o        - fetch in progress / fields final pulse
//            icode_o, ifun_o, rA_o, rB_o, valC_o, valP_o, stat_o
//            srcA_o, srcB_o, dstE_o, dstM_o - register-file IDs
// Config   : FETCH_IFUN_CHECK_EN - when defined, an ifun value outside the
//            legal set for its icode yields stat INS, with length 1.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_decode (
    input  logic        clock,
    input  logic        reset,
    input  logic        start_i,
    input  logic [63:0] pc_i,
    output logic        imem_req_o,
    output logic [63:0] imem_addr_o,
    input  logic        imem_valid_i,
    input  logic [7:0]  imem_rdata_i,
    input  logic        imem_error_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [3:0]  icode_o,
    output logic [3:0]  ifun_o,
    output logic [3:0]  rA_o,
    output logic [3:0]  rB_o,
    output logic [63:0] valC_o,
    output logic [63:0] valP_o,
    output logic [3:0]  srcA_o,
    output logic [3:0]  srcB_o,
    output logic [3:0]  dstE_o,
    output logic [3:0]  dstM_o,
    output logic [2:0]  stat_o
);

    localparam logic [3:0] c_NONE     = 4'hF;
    localparam logic [3:0] c_RSP      = 4'h4;
    localparam logic [2:0] c_STAT_AOK = 3'd1;
    localparam logic [2:0] c_STAT_HLT = 3'd2;
    localparam logic [2:0] c_STAT_ADR = 3'd3;
    localparam logic [2:0] c_STAT_INS = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_OPC   = 3'd1,
        S_REGS  = 3'd2,
        S_CONST = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] valc_q, valc_d;
    logic [63:0] valp_q, valp_d;
    logic [3:0]  icode_q, icode_d;
    logic [3:0]  ifun_q, ifun_d;
    logic [3:0]  ra_q, ra_d;
    logic [3:0]  rb_q, rb_d;
    logic [2:0]  stat_q, stat_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        done_q, done_d;

    function automatic logic need_regids(input logic [3:0] ic);
        logic r;
        case (ic)
            4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB: r = 1'b1;
            default:                                  r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic need_valc(input logic [3:0] ic);
        logic r;
        case (ic)
            4'h3, 4'h4, 4'h5, 4'h7, 4'h8: r = 1'b1;
            default:                      r = 1'b0;
        endcase
        return r;
    endfunction

`ifdef FETCH_IFUN_CHECK_EN
    function automatic logic ifun_bad(input logic [3:0] ic, input logic [3:0] fn);
        logic r;
        case (ic)
            4'h2, 4'h7: r = (fn > 4'h6);
            4'h6:       r = (fn > 4'h3);
            default:    r = (fn != 4'h0);
        endcase
        return r;
    endfunction
`endif

    logic [3:0] w_op_ic;
    logic [3:0] w_op_fn;
    logic       w_op_bad;

    assign w_op_ic = imem_rdata_i[7:4];
    assign w_op_fn = imem_rdata_i[3:0];
`ifdef FETCH_IFUN_CHECK_EN
    assign w_op_bad = (w_op_ic > 4'hB) || ifun_bad(w_op_ic, w_op_fn);
`else
    assign w_op_bad = (w_op_ic > 4'hB);
`endif

    // Next-state logic. addr_q always points at the byte being requested, so
    // on a fault it equals pc + bytes consumed, and on the last good byte
    // addr_q + 1 equals pc + instruction length.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        valc_d  = valc_q;
        valp_d  = valp_q;
        icode_d = icode_q;
        ifun_d  = ifun_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        stat_d  = stat_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                // done_q high means this is the done cycle: ignore start.
                if (start_i && !done_q) begin
                    state_d = S_OPC;
                    addr_d  = pc_i;
                    valc_d  = 64'd0;
                    valp_d  = 64'd0;
                    icode_d = 4'h0;
                    ifun_d  = 4'h0;
                    ra_d    = c_NONE;
                    rb_d    = c_NONE;
                    stat_d  = c_STAT_AOK;
                end
            end
            S_OPC: begin
                if (imem_valid_i) begin
                    if (imem_error_i) begin
                        stat_d  = c_STAT_ADR;
                        valp_d  = addr_q;
                        state_d = S_DONE;
                    end else begin
                        icode_d = w_op_ic;
                        ifun_d  = w_op_fn;
                        addr_d  = addr_q + 64'd1;
                        if (w_op_bad) begin
                            stat_d  = c_STAT_INS;
                            valp_d  = addr_q + 64'd1;
                            state_d = S_DONE;
                        end else if (w_op_ic == 4'h0 || w_op_ic == 4'h1 || w_op_ic == 4'h9) begin
                            if (w_op_ic == 4'h0) begin
                                stat_d = c_STAT_HLT;
                            end
                            valp_d  = addr_q + 64'd1;
                            state_d = S_DONE;
                        end else if (need_regids(w_op_ic)) begin
                            state_d = S_REGS;
                        end else begin
                            cnt_d   = 3'd0;
                            state_d = S_CONST;
                        end
                    end
                end
            end
            S_REGS: begin
                if (imem_valid_i) begin
                    if (imem_error_i) begin
                        stat_d  = c_STAT_ADR;
                        valp_d  = addr_q;
                        state_d = S_DONE;
                    end else begin
                        ra_d   = imem_rdata_i[7:4];
                        rb_d   = imem_rdata_i[3:0];
                        addr_d = addr_q + 64'd1;
                        if (need_valc(icode_q)) begin
                            cnt_d   = 3'd0;
                            state_d = S_CONST;
                        end else begin
                            valp_d  = addr_q + 64'd1;
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_CONST: begin
                if (imem_valid_i) begin
                    if (imem_error_i) begin
                        stat_d  = c_STAT_ADR;
                        valp_d  = addr_q;
                        state_d = S_DONE;
                    end else begin
                        valc_d[{cnt_q, 3'b000} +: 8] = imem_rdata_i;
                        addr_d = addr_q + 64'd1;
                        cnt_d  = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            valp_d  = addr_q + 64'd1;
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= 64'd0;
            valc_q  <= 64'd0;
            valp_q  <= 64'd0;
            icode_q <= 4'h0;
            ifun_q  <= 4'h0;
            ra_q    <= c_NONE;
            rb_q    <= c_NONE;
            stat_q  <= c_STAT_AOK;
            cnt_q   <= 3'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            valc_q  <= valc_d;
            valp_q  <= valp_d;
            icode_q <= icode_d;
            ifun_q  <= ifun_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            stat_q  <= stat_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Register-file IDs decoded from the captured fields; any non-AOK status
    // suppresses every read and write.
    always_comb begin
        srcA_o = c_NONE;
        srcB_o = c_NONE;
        dstE_o = c_NONE;
        dstM_o = c_NONE;
        if (stat_q == c_STAT_AOK) begin
            case (icode_q)
                4'h2, 4'h4, 4'h6, 4'hA: srcA_o = ra_q;
                4'h9, 4'hB:             srcA_o = c_RSP;
                default:                srcA_o = c_NONE;
            endcase
            case (icode_q)
                4'h4, 4'h5, 4'h6:       srcB_o = rb_q;
                4'h8, 4'h9, 4'hA, 4'hB: srcB_o = c_RSP;
                default:                srcB_o = c_NONE;
            endcase
            case (icode_q)
                4'h2, 4'h3, 4'h6:       dstE_o = rb_q;
                4'h8, 4'h9, 4'hA, 4'hB: dstE_o = c_RSP;
                default:                dstE_o = c_NONE;
            endcase
            case (icode_q)
                4'h5, 4'hB: dstM_o = ra_q;
                default:    dstM_o = c_NONE;
            endcase
        end
    end

    assign imem_req_o  = (state_q == S_OPC) || (state_q == S_REGS) || (state_q == S_CONST);
    assign imem_addr_o = addr_q;
    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = done_q;
    assign icode_o     = icode_q;
    assign ifun_o      = ifun_q;
    assign rA_o        = ra_q;
    assign rB_o        = rb_q;
    assign valC_o      = valc_q;
    assign valP_o      = valp_q;
    assign stat_o      = stat_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_decode.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_decode
// Purpose  : Self-checking bench for fetch_decode. A byte memory with
//            programmable wait states and a fault offset answers requests;
//            expected results come from an instruction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_decode;

    logic        clock;
    logic        reset;
    logic        start_i;
    logic [63:0] pc_i;
    logic        imem_req_o;
    logic [63:0] imem_addr_o;
    logic        imem_valid_i;
    logic [7:0]  imem_rdata_i;
    logic        imem_error_i;
    logic        busy_o;
    logic        done_o;
    logic [3:0]  icode_o, ifun_o, rA_o, rB_o;
    logic [63:0] valC_o, valP_o;
    logic [3:0]  srcA_o, srcB_o, dstE_o, dstM_o;
    logic [2:0]  stat_o;

    fetch_decode u_dut (
        .clock        (clock),
        .reset        (reset),
        .start_i      (start_i),
        .pc_i         (pc_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_valid_i (imem_valid_i),
        .imem_rdata_i (imem_rdata_i),
        .imem_error_i (imem_error_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .icode_o      (icode_o),
        .ifun_o       (ifun_o),
        .rA_o         (rA_o),
        .rB_o         (rB_o),
        .valC_o       (valC_o),
        .valP_o       (valP_o),
        .srcA_o       (srcA_o),
        .srcB_o       (srcB_o),
        .dstE_o       (dstE_o),
        .dstM_o       (dstM_o),
        .stat_o       (stat_o)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Byte memory: instruction bytes relative to mem_base, mem_wait idle
    // cycles before every response, fault on byte offset mem_eoff (-1 none).
    // ------------------------------------------------------------------
    logic [7:0]  mem_b [16];
    logic [63:0] mem_base = 64'd0;
    int          mem_wait = 0;
    int          mem_eoff = -1;

    initial begin
        int          wcnt;
        logic [63:0] off;
        wcnt         = 0;
        imem_valid_i = 1'b0;
        imem_rdata_i = 8'h00;
        imem_error_i = 1'b0;
        forever begin
            @(negedge clock);
            if (imem_req_o) begin
                off = imem_addr_o - mem_base;
                if (wcnt < mem_wait) begin
                    wcnt++;
                    imem_valid_i = 1'b0;
                    imem_rdata_i = 8'($urandom);
                    imem_error_i = 1'($urandom);
                end else begin
                    wcnt = 0;
                    imem_valid_i = 1'b1;
                    imem_rdata_i = (off < 64'd16) ? mem_b[off[3:0]] : 8'h00;
                    imem_error_i = (mem_eoff >= 0) && (off == 64'(mem_eoff));
                end
            end else begin
                wcnt         = 0;
                imem_valid_i = 1'b0;
                imem_error_i = 1'b0;
            end
        end
    end

    task automatic set_mem(input logic [79:0] bs);
        for (int i = 0; i < 16; i++) begin
            mem_b[i] = (i < 10) ? bs[79 - 8*i -: 8] : 8'($urandom);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: decodes the bytes in mem_b at instruction level.
    // ------------------------------------------------------------------
    typedef struct {
        logic [3:0]  icode, ifun, ra, rb, sa, sb, de, dm;
        logic [63:0] valc, valp;
        logic [2:0]  stat;
        int          nbytes;
    } exp_t;

    function automatic exp_t model(input logic [63:0] pc, input int eoff);
        exp_t e;
        logic [3:0] ic, fn;
        bit bad, nr, nc;
        int len;
        ic  = mem_b[0][7:4];
        fn  = mem_b[0][3:0];
        bad = (ic > 4'hB);
`ifdef FETCH_IFUN_CHECK_EN
        case (ic)
            4'h2, 4'h7: if (fn > 4'h6) bad = 1;
            4'h6:       if (fn > 4'h3) bad = 1;
            default:    if (fn != 4'h0) bad = 1;
        endcase
`endif
        nr  = !bad && (ic inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB});
        nc  = !bad && (ic inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8});
        len = 1 + (nr ? 1 : 0) + (nc ? 8 : 0);
        e.icode = ic;
        e.ifun  = fn;
        e.ra    = nr ? mem_b[1][7:4] : 4'hF;
        e.rb    = nr ? mem_b[1][3:0] : 4'hF;
        e.valc  = 64'd0;
        if (nc) begin
            for (int k = 0; k < 8; k++) e.valc[8*k +: 8] = mem_b[k + (nr ? 2 : 1)];
        end
        if (eoff >= 0 && eoff < len) begin
            e.stat   = 3'd3;
            e.valp   = pc + 64'(eoff);
            e.nbytes = eoff + 1;
        end else begin
            e.stat   = bad ? 3'd4 : (ic == 4'h0) ? 3'd2 : 3'd1;
            e.valp   = pc + 64'(len);
            e.nbytes = len;
        end
        e.sa = 4'hF; e.sb = 4'hF; e.de = 4'hF; e.dm = 4'hF;
        if (e.stat == 3'd1) begin
            if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) e.sa = e.ra;
            if (ic inside {4'h9, 4'hB})             e.sa = 4'h4;
            if (ic inside {4'h4, 4'h5, 4'h6})       e.sb = e.rb;
            if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) e.sb = 4'h4;
            if (ic inside {4'h2, 4'h3, 4'h6})       e.de = e.rb;
            if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) e.de = 4'h4;
            if (ic inside {4'h5, 4'hB})             e.dm = e.ra;
        end
        return e;
    endfunction

    // One fetch: start at pc, wait for done, compare against the model.
    // poke re-asserts start (other pc) while busy; start_on_done drives start
    // in the done cycle, which must be ignored.
    task automatic run(input logic [63:0] pc, input int wt, input int eoff,
                       input bit poke, input bit start_on_done, output int lat);
        exp_t e;
        int   cyc;
        bit   seen;
        e = model(pc, eoff);
        @(negedge clock);
        mem_base = pc;
        mem_wait = wt;
        mem_eoff = eoff;
        start_i  = 1'b1;
        pc_i     = pc;
        @(posedge clock);
        #1;
        start_i = 1'b0;
        cyc  = 0;
        seen = 0;
        while (!seen && cyc < 300) begin
            @(posedge clock);
            cyc++;
            #1;
            if (cyc == 1) check("busy_after_start", 64'(busy_o), 64'd1);
            if (done_o) seen = 1;
            if (poke && cyc == 1 && !seen) begin
                start_i = 1'b1;
                pc_i    = ~pc;
            end else begin
                start_i = 1'b0;
            end
        end
        lat = cyc;
        check("latency", 64'(cyc), 64'(e.nbytes * (wt + 1) + 1));
        check("stat", 64'(stat_o), 64'(e.stat));
        check("valP", valP_o, e.valp);
        check("srcA", 64'(srcA_o), 64'(e.sa));
        check("srcB", 64'(srcB_o), 64'(e.sb));
        check("dstE", 64'(dstE_o), 64'(e.de));
        check("dstM", 64'(dstM_o), 64'(e.dm));
        if (e.stat != 3'd3) begin
            check("icode", 64'(icode_o), 64'(e.icode));
            check("ifun", 64'(ifun_o), 64'(e.ifun));
            check("rA", 64'(rA_o), 64'(e.ra));
            check("rB", 64'(rB_o), 64'(e.rb));
            check("valC", valC_o, e.valc);
        end
        if (start_on_done) start_i = 1'b1;
        @(posedge clock);
        #1;
        start_i = 1'b0;
        check("done_single_pulse", 64'(done_o), 64'd0);
        if (start_on_done) check("start_in_done_ignored", 64'(busy_o), 64'd0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int dn;
        reset   = 1'b1;
        start_i = 1'b0;
        pc_i    = 64'd0;
        set_mem(80'h0);
        repeat (3) @(posedge clock);
        #1;
        check("rst_req", 64'(imem_req_o), 64'd0);
        check("rst_addr", imem_addr_o, 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_done", 64'(done_o), 64'd0);
        check("rst_icode", 64'({icode_o, ifun_o}), 64'h00);
        check("rst_valC", valC_o, 64'd0);
        check("rst_valP", valP_o, 64'd0);
        check("rst_rArB", 64'({rA_o, rB_o}), 64'hFF);
        check("rst_ids", 64'({srcA_o, srcB_o, dstE_o, dstM_o}), 64'hFFFF);
        check("rst_stat", 64'(stat_o), 64'd1);
        reset = 1'b0;

        // irmovq-style 10-byte instruction, zero wait.
        set_mem(80'h30F3EFCDAB8967452301);
        run(64'h100, 0, -1, 0, 0, lat);
        check("t1_latency", 64'(lat), 64'd11);
        check("t1_valC", valC_o, 64'h0123456789ABCDEF);
        check("t1_valP", valP_o, 64'h10A);
        check("t1_dstE", 64'(dstE_o), 64'd3);

        // addq with two wait cycles per byte.
        set_mem({16'h6012, 64'h0});
        run(64'h20, 2, -1, 0, 0, lat);
        check("t2_latency", 64'(lat), 64'd7);
        check("t2_ids", 64'({srcA_o, srcB_o, dstE_o, dstM_o}), 64'h122F);
        check("t2_valP", valP_o, 64'h22);

        set_mem({16'hB00F, 64'h0});
        run(64'h500, 1, -1, 0, 0, lat);
        check("popq_ids", 64'({srcA_o, srcB_o, dstE_o, dstM_o}), 64'h4440);

        set_mem({8'h90, 72'h0});
        run(64'h600, 0, -1, 0, 1, lat);
        check("ret_ids", 64'({srcA_o, srcB_o, dstE_o}), 64'h444);
        check("ret_valP", valP_o, 64'h601);

        set_mem({8'h00, 72'h0});
        run(64'h700, 0, -1, 0, 0, lat);
        check("halt_stat", 64'(stat_o), 64'd2);
        check("halt_valP", valP_o, 64'h701);

        set_mem({8'hC0, 72'h0});
        run(64'h800, 0, -1, 0, 0, lat);
        check("ins_stat", 64'(stat_o), 64'd4);
        check("ins_ids", 64'({srcA_o, srcB_o, dstE_o, dstM_o}), 64'hFFFF);

        // Call with fault on its 4th byte.
        set_mem(80'h80112233445566778899);
        run(64'h0, 0, 3, 0, 0, lat);
        check("adr_stat", 64'(stat_o), 64'd3);
        check("adr_valP", valP_o, 64'd3);
        check("adr_latency", 64'(lat), 64'd5);

        set_mem({16'h6512, 64'h0});
        run(64'h900, 0, -1, 0, 0, lat);
`ifdef FETCH_IFUN_CHECK_EN
        check("ifun65_stat", 64'(stat_o), 64'd4);
`else
        check("ifun65_stat", 64'(stat_o), 64'd1);
`endif

        // Start while busy must not re-latch pc.
        set_mem(80'h70AABBCCDDEEFF001122);
        run(64'h40, 1, -1, 1, 0, lat);
        check("poke_valP", valP_o, 64'h49);

        set_mem({8'h10, 72'h0});
        run(64'hFFFF_FFFF_FFFF_FFFF, 0, -1, 0, 0, lat);
        check("wrap_valP", valP_o, 64'd0);

        // Reset during the constant phase.
        set_mem(80'h30F3EFCDAB8967452301);
        @(negedge clock);
        mem_base = 64'h300;
        mem_wait = 0;
        mem_eoff = -1;
        start_i  = 1'b1;
        pc_i     = 64'h300;
        @(posedge clock);
        #1;
        start_i = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("mid_busy", 64'(busy_o), 64'd1);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("mid_rst_req", 64'(imem_req_o), 64'd0);
        check("mid_rst_busy", 64'(busy_o), 64'd0);
        dn = 0;
        for (int i = 0; i < 20; i++) begin
            if (done_o) dn++;
            @(posedge clock);
            #1;
        end
        check("mid_rst_no_done", 64'(dn), 64'd0);

        // Randomized instructions, waits, faults and addresses.
        for (int n = 0; n < 40; n++) begin
            logic [3:0]  ic, fn;
            logic [63:0] pc;
            int          eo;
            ic = 4'($urandom_range(0, 15));
            fn = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            set_mem({ic, fn, 72'({$urandom, $urandom, $urandom})});
            pc = ($urandom_range(0, 4) == 0) ? (64'hFFFF_FFFF_FFFF_FFF8 + 64'($urandom_range(0, 7)))
                                             : {$urandom, $urandom};
            eo = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9)) : -1;
            run(pc, int'($urandom_range(0, 2)), eo, bit'($urandom_range(0, 1)),
                bit'($urandom_range(0, 1)), lat);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_decode.md
# fetch_decode

Sequential Y86-64 fetch-and-decode block that sits directly upstream of the register file. On a start pulse it reads one instruction byte-by-byte from a byte-wide instruction memory and extracts the instruction fields. It then drives the register IDs the register file consumes: srcA/srcB for reads, dstE/dstM for writes, with 4'hF meaning "none". It also produces valC, valP and an instruction status for the execute and PC-update stages.

## Interface
- No parameters; the data path is fixed at 64 bits and register IDs are 4 bits.
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  begin fetch at pc; honoured only in IDLE.
- pc  in  64  address of the instruction; sampled on the accepted start.
- imem_req  out  1  byte read request; held until imem_valid.
- imem_addr  out  64  byte address of the current request.
- imem_valid  in  1  rdata/error valid this cycle; same-cycle response allowed.
- imem_rdata  in  8  returned byte.
- imem_error  in  1  address fault; qualified by imem_valid.
- busy  out  1  high from the accepted start until done.
- done  out  1  one-cycle pulse when the output fields are final.
- icode, ifun  out  4 each  opcode nibbles.
- rA, rB  out  4 each  register specifiers; 4'hF if the instruction has no register byte.
- valC  out  64  little-endian constant; 0 if the instruction has none.
- valP  out  64  pc + instruction length, modulo 2^64.
- srcA, srcB, dstE, dstM  out  4 each  register-file IDs; 4'hF = none.
- stat  out  3  1 AOK, 2 HLT, 3 ADR, 4 INS.

## Operation
- FSM states: IDLE, OPC, REGS, CONST, DONE.
- IDLE + start: latch pc, enter OPC. start while busy is ignored.
- OPC: request byte at pc. On valid, capture icode/ifun.
  - icode 0 or 9, icode 1, and an invalid icode (>4'hB) go to DONE. Any other icode goes to REGS if need_regids, else CONST.
- Register byte needed (need_regids) for icodes 2,3,4,5,6,A,B. REGS reads pc+1 and captures rA from the high nibble and rB from the low nibble.
- Constant needed (need_valC) for icodes 3,4,5,7,8. CONST reads 8 bytes; byte k sets valC[8k+7:8k]. The constant starts at pc+2 if need_regids, else pc+1.
- Instruction lengths:
  - 1 byte: icodes 0, 1, 9.
  - 2 bytes: icodes 2, 6, A, B.
  - 9 bytes: icodes 7, 8.
  - 10 bytes: icodes 3, 4, 5.
  - Invalid icode: 1 byte.
- Status is evaluated in priority order ADR > INS > HLT > AOK:
  - imem_error on any byte: stat ADR, abort to DONE immediately, valP = pc + bytes consumed.
  - Invalid icode: stat INS.
  - icode 0: stat HLT.
  - Otherwise: stat AOK.
- Register-ID mapping (RSP = 4):
  - srcA: rA for icodes 2,4,6,A; RSP for 9,B; otherwise F.
  - srcB: rB for icodes 4,5,6; RSP for 8,9,A,B; otherwise F.
  - dstE: rB for icodes 2,3,6; RSP for 8,9,A,B; otherwise F. cmov gating for icode 2 is done downstream.
  - dstM: rA for icodes 5,B; otherwise F.
  - Every register ID is forced to F when stat is not AOK.
- DONE: pulse done, return to IDLE. Outputs hold until the next accepted start.

## Timing
- Reset values:
  - FSM returns to IDLE.
  - busy, done, imem_req = 0; imem_addr = 0.
  - icode, ifun = 0; valC, valP = 0.
  - rA, rB, srcA, srcB, dstE, dstM = 4'hF.
  - stat = 1 (AOK).
- Reset mid-fetch aborts the fetch, drops imem_req the next cycle, and produces no done pulse.
- imem_req is asserted from the cycle after start; each byte completes on the rising edge where imem_valid = 1.
- With a zero-wait memory, done asserts N+1 cycles after the start edge for an N-byte instruction. Each wait cycle adds one cycle.
- imem_addr and imem_req stay stable while imem_valid = 0.
- A start in the same cycle as done is ignored; a start on the following cycle is accepted.

## Configuration
- FETCH_IFUN_CHECK_EN defined: an invalid ifun also gives stat INS and terminates like an invalid icode, with length 1. Valid ifun values:
  - icode 2: 0-6. icode 6: 0-3. icode 7: 0-6.
  - All other icodes: ifun must be 0.
- FETCH_IFUN_CHECK_EN undefined: ifun is passed through unchecked, and only icode validity affects stat.

## Test plan
- Zero-wait memory, pc=0x100, bytes 30 F3 EF CD AB 89 67 45 23 01 -> done at cycle 11, icode 3, rB 3, valC 0x0123456789ABCDEF, valP 0x10A, dstE 3, srcA/srcB/dstM F, stat 1.
- pc=0x20, bytes 60 12 (addq) with 2 wait cycles per byte -> done at cycle 7, srcA 1, srcB 2, dstE 2, dstM F, valP 0x22.
- Bytes B0 0F (popq %rax) -> srcA 4, srcB 4, dstE 4, dstM 0. Byte 90 (ret) -> srcA 4, srcB 4, dstE 4, valP pc+1.
- Byte 00 -> stat 2, valP pc+1. Byte C0 -> stat 4, all register IDs F.
- imem_error on the 4th byte of a call at pc=0 -> stat 3, done 1 cycle after the faulting byte, valP 3. Separately, a 65 byte with FETCH_IFUN_CHECK_EN -> stat 4; without it -> stat 1.
- Reset asserted during CONST -> next cycle imem_req 0, busy 0, no done. start=1 while busy -> ignored and pc not re-latched. pc=0xFFFFFFFFFFFFFFFF with byte 10 -> valP 0.
